// File: rtl/sdpram_rr_arbiter_pkg.sv
// Shared definitions for the dual-port RAM front-end arbiter.
package sdpram_rr_arbiter_pkg;

  // Controller phases: INIT sweeps the RAM, RUN serves requesters.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Round-robin pointer value that favours requester 0 on a tie.
  localparam logic PTR_FAVOUR_REQ0 = 1'b0;

  // True when requester 1 wins a two-way round-robin decision.
  // Requester 1 wins if it is the only one asking, or both ask
  // and the pointer currently favours it.
  function automatic logic rr_pick_req1(input logic req0,
                                        input logic req1,
                                        input logic ptr);
    return req1 && (!req0 || (ptr != PTR_FAVOUR_REQ0));
  endfunction

endpackage

// File: rtl/sdpram_rr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with its own fairness pointer.
// Grants are purely combinational from the requests and the pointer;
// the pointer only moves when a grant is actually issued.
module rr_arb2
  import sdpram_rr_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptr_q;
  logic ptr_d;
  logic pick1;

  // Grant decision: nothing is granted while the arbiter is disabled.
  always_comb begin
    pick1 = rr_pick_req1(req0, req1, ptr_q);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (en) begin
      gnt1 = pick1;
      gnt0 = req0 && !pick1;
    end
  end

  // After a grant, hand priority to the requester that did not win.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d = PTR_FAVOUR_REQ0;
    end
  end

  // Pointer register, cleared so requester 0 is favoured after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_FAVOUR_REQ0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sdpram_rr_arbiter.sv
// Front end for a simple dual-port RAM: after reset it sweeps every
// word to INIT_VALUE, then arbitrates two write and two read
// requesters onto the RAM's single write port and single read port.
// Read data comes straight from the RAM's registered output; the RAM
// itself forwards same-cycle writes, so no bypass logic lives here.
module sdpram_rr_arbiter
  import sdpram_rr_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 4,
  parameter int                    DEPTH      = 2 ** ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req0,
  input  logic                  wr_req1,
  input  logic [ADDR_WIDTH-1:0] wr_addr0,
  input  logic [ADDR_WIDTH-1:0] wr_addr1,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  output logic                  wr_gnt0,
  output logic                  wr_gnt1,
  input  logic                  rd_req0,
  input  logic                  rd_req1,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic                  rd_gnt0,
  output logic                  rd_gnt1,
  output logic                  rd_vld0,
  output logic                  rd_vld1,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_re_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_e                  state_q;
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   cnt_d;
  logic                    init_done_q;
  logic                    init_done_d;
  logic                    rd_vld0_q;
  logic                    rd_vld0_d;
  logic                    rd_vld1_q;
  logic                    rd_vld1_d;
  logic                    run;

  assign run = (state_q == ST_RUN);

  rr_arb2 u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .req0 (wr_req0),
    .req1 (wr_req1),
    .gnt0 (wr_gnt0),
    .gnt1 (wr_gnt1)
  );

  rr_arb2 u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .req0 (rd_req0),
    .req1 (rd_req1),
    .gnt0 (rd_gnt0),
    .gnt1 (rd_gnt1)
  );

  // RAM port steering: the sweep owns the write port during INIT,
  // otherwise each port follows its arbiter winner.
  always_comb begin
    ram_re_en  = rd_gnt0 || rd_gnt1;
    ram_addr_b = rd_gnt1 ? rd_addr1 : rd_addr0;
    if (run) begin
      ram_wr_en  = wr_gnt0 || wr_gnt1;
      ram_addr_a = wr_gnt1 ? wr_addr1 : wr_addr0;
      ram_data_a = wr_gnt1 ? wr_data1 : wr_data0;
    end else begin
      ram_wr_en  = 1'b1;
      ram_addr_a = cnt_q;
      ram_data_a = INIT_VALUE;
    end
  end

  // Next-state logic: step the sweep counter and leave INIT right
  // after the last address has been written; read responses follow
  // their grant by exactly one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rd_vld0_d   = rd_gnt0;
    rd_vld1_d   = rd_gnt1;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_ONE;
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Controller registers; reset restarts the sweep and drops any read
  // that was granted in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_vld0_q   <= 1'b0;
      rd_vld1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_vld0_q   <= rd_vld0_d;
      rd_vld1_q   <= rd_vld1_d;
    end
  end

  assign init_done = init_done_q;
  assign rd_vld0   = rd_vld0_q;
  assign rd_vld1   = rd_vld1_q;
  assign rd_data   = ram_data_b;

endmodule

// File: doc/sdpram_rr_arbiter.md
SDPRAM_RR_ARBITER -- requirements
Module: sdpram_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, RAM data width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_WIDTH, number of RAM words to initialise.
REQ-004 SHALL have parameter INIT_VALUE, default 0, word written to every address by the init sweep.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports wr_req0/wr_req1  input  1  write request per requester.
REQ-008 SHALL have ports wr_addr0/wr_addr1  input  ADDR_WIDTH, and wr_data0/wr_data1  input  DATA_WIDTH  write address and data.
REQ-009 SHALL have ports wr_gnt0/wr_gnt1  output  1  write accepted this cycle (combinational).
REQ-010 SHALL have ports rd_req0/rd_req1  input  1, rd_addr0/rd_addr1  input  ADDR_WIDTH  read requests.
REQ-011 SHALL have ports rd_gnt0/rd_gnt1  output  1  read accepted this cycle (combinational).
REQ-012 SHALL have ports rd_vld0/rd_vld1  output  1, rd_data  output  DATA_WIDTH  registered read response.
REQ-013 SHALL have ports ram_wr_en  output  1, ram_addr_a  output  ADDR_WIDTH, ram_data_a  output  DATA_WIDTH  RAM write port.
REQ-014 SHALL have ports ram_re_en  output  1, ram_addr_b  output  ADDR_WIDTH, ram_data_b  input  DATA_WIDTH  RAM read port (1-cycle latency, same-cycle write-to-read forwarding inside RAM).
REQ-015 SHALL have port init_done  output  1  high once the init sweep completes.

Function
REQ-016 SHALL implement FSM with states INIT and RUN; reset enters INIT with sweep counter 0.
REQ-017 In INIT SHALL drive ram_wr_en=1, ram_addr_a=counter, ram_data_a=INIT_VALUE each cycle; counter increments by 1.
REQ-018 SHALL transition INIT->RUN in the cycle after the write to address DEPTH-1; sweep takes exactly DEPTH cycles.
REQ-019 In INIT SHALL hold all wr_gnt*, rd_gnt*, ram_re_en at 0 and init_done at 0.
REQ-020 In RUN SHALL hold init_done at 1 until the next reset.
REQ-021 In RUN SHALL grant at most one write per cycle: sole requester wins; on a tie the requester indicated by wr_ptr wins.
REQ-022 SHALL update wr_ptr only on a granted write, to the index of the non-winning requester (round-robin).
REQ-023 SHALL arbitrate reads identically with independent rd_ptr; reads and writes proceed in parallel in the same cycle.
REQ-024 SHALL drive ram_wr_en = OR of wr_gnt*, with ram_addr_a/ram_data_a muxed from the winner; ram_re_en/ram_addr_b likewise from the read winner.
REQ-025 SHALL assert rd_vldN exactly one cycle after rd_gntN, with rd_data = ram_data_b in that cycle; rd_data is don't-care when no rd_vld is high.
REQ-026 Read and write to the same address in the same cycle SHALL return the newly written data (relies on RAM forwarding; no extra logic).
REQ-027 Back-to-back grants to the same requester SHALL be allowed when the other does not request; throughput 1 read + 1 write per cycle.
REQ-028 Gnt outputs SHALL be combinational from req and pointer; no request is held internally across cycles.

Reset
REQ-029 On rst SHALL set: state=INIT, counter=0, wr_ptr=0, rd_ptr=0, rd_vld0/1=0, init_done=0.
REQ-030 Reset mid-RUN or mid-INIT SHALL restart the full sweep; a read granted in the reset cycle SHALL produce no rd_vld.

Structure
REQ-031 SHALL place FSM state encoding (INIT, RUN) in the shared package; widths stay module parameters.
REQ-032 SHALL instantiate one sub-module rr_arb2 (2-way round-robin grant + pointer), used twice for read and write.

Verification
REQ-033 Reset, DEPTH=16 -> ram_wr_en high 16 cycles at addresses 0..15 with data 0; init_done rises cycle 17; no gnt during sweep.
REQ-034 RUN, wr_req0=wr_req1=1 held 4 cycles -> grants alternate 0,1,0,1.
REQ-035 rd_req1=1 addr 5 after write of 0xA to 5 -> rd_gnt1 that cycle, rd_vld1=1 and rd_data=0xA next cycle.
REQ-036 Same cycle: wr_req0 addr 3 data 0x7, rd_req0 addr 3 -> next cycle rd_vld0=1, rd_data=0x7.
REQ-037 rst pulsed while rd_req0 granted in RUN -> no rd_vld0 next cycle, init_done=0, sweep restarts at address 0.
